// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int INSTR_BYTES   = 4;
   localparam int PC_ALIGN_BITS = $clog2(INSTR_BYTES);

   // Reference widths for the shared record types below.
   localparam int FETCH_XLEN  = 32;
   localparam int FETCH_PCLEN = 32;

   typedef struct packed {
      logic [FETCH_PCLEN-1:0] pc;
      logic [FETCH_XLEN-1:0]  instr;
      logic                   dv;
   } fetch_entry_t;

   typedef struct packed {
      logic                   valid;
      logic [FETCH_PCLEN-1:0] pc;
   } redirect_t;

   // Width of a counter that must be able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Bus bundle between the fetch buffer, instruction memory, the branch
// unit and decode. The master side is the fetch buffer itself.
interface fetch_buffer_if #(
   parameter int XLEN  = 32,
   parameter int PCLEN = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [PCLEN-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [XLEN-1:0]  imem_rsp_data;
   logic             redirect_valid;
   logic [PCLEN-1:0] redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_instr;
   logic [PCLEN-1:0] out_pc;
   logic [CW-1:0]    occupancy;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output out_valid, out_instr, out_pc,
      input  out_ready,
      output occupancy
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  out_valid, out_instr, out_pc,
      output out_ready,
      input  occupancy
   );

endinterface

// File: rtl/fetch_ring.sv
// DEPTH-entry prefetch ring. Entries are allocated at the tail, filled
// in order at the fill pointer and retired at the head. A flush frees
// every entry at once; stale storage contents are harmless because an
// allocation always clears the data-valid bit.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PCLEN = 32,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [PCLEN-1:0] push_pc_i,
   input  logic             fill_i,
   input  logic             fill_wr_i,
   input  logic [XLEN-1:0]  fill_data_i,
   input  logic             pop_i,
   output logic [PCLEN-1:0] head_pc_o,
   output logic [XLEN-1:0]  head_instr_o,
   output logic             head_dv_o,
   output logic [CW-1:0]    occ_o,
   output logic [CW-1:0]    pend_o
);

   logic [PCLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0]  instr_q [DEPTH];
   logic [DEPTH-1:0] dv_q;
   logic [PW-1:0]    head_q, fill_q, tail_q;
   logic [CW-1:0]    occ_q, pend_q;

   // Entry storage: allocation writes the PC, fill writes the instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         dv_q <= '0;
      end else if (!flush_i) begin
         if (push_i) begin
            pc_q[tail_q] <= push_pc_i;
            dv_q[tail_q] <= 1'b0;
         end
         if (fill_i && fill_wr_i) begin
            instr_q[fill_q] <= fill_data_i;
            dv_q[fill_q]    <= 1'b1;
         end
      end
   end

   // Pointers and counters; a fill advances the pointer even when the
   // write is suppressed because the entry is being popped by bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         fill_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         pend_q <= '0;
      end else if (flush_i) begin
         head_q <= '0;
         fill_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         pend_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + PW'(1);
         if (fill_i) fill_q <= fill_q + PW'(1);
         if (pop_i)  head_q <= head_q + PW'(1);
         occ_q  <= occ_q  + CW'(push_i) - CW'(pop_i);
         pend_q <= pend_q + CW'(push_i) - CW'(fill_i);
      end
   end

   assign head_pc_o    = pc_q[head_q];
   assign head_instr_o = instr_q[head_q];
   assign head_dv_o    = dv_q[head_q];
   assign occ_o        = occ_q;
   assign pend_o       = pend_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end with a decoupling prefetch ring.
// Generates sequential PCs, issues requests to instruction memory,
// accepts in-order responses and delivers instructions to decode.
// A redirect flushes the ring and discards responses still in flight.
// Optional build macro: FETCH_BUFFER_BYPASS_EN forwards a response
// straight to decode when it completes the only entry in the ring.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               PCLEN    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [PCLEN-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   fetch_buffer_if.master bus
);

   localparam int               CW         = cnt_width(DEPTH);
   localparam logic [CW-1:0]    DEPTH_C    = CW'(DEPTH);
   localparam logic [PCLEN-1:0] PC_STEP    = PCLEN'(INSTR_BYTES);
   localparam logic [PCLEN-1:0] ALIGN_MASK = ~PCLEN'(INSTR_BYTES - 1);

   logic [PCLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic [CW:0]      drop_sum;
   logic [CW-1:0]    occ, pend;
   logic             req_fire, fill, fill_wr, pop;
   logic [PCLEN-1:0] head_pc;
   logic [XLEN-1:0]  head_instr;
   logic             head_dv;

   // Held low through reset so nothing is requested until it releases.
   assign bus.imem_req_valid = ~reset & (occ < DEPTH_C) & ~bus.redirect_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.occupancy      = occ;

   assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
   assign fill     = bus.imem_rsp_valid & ~bus.redirect_valid & (drop_q == '0);
   assign pop      = bus.out_valid & bus.out_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
   logic bypass;
   assign bypass = fill & (occ == CW'(1)) & (pend == CW'(1));

   // Decode view: registered head, or the arriving beat when it completes the sole entry.
   always_comb begin
      bus.out_valid = ~bus.redirect_valid & (((occ != '0) & head_dv) | bypass);
      bus.out_instr = bypass ? bus.imem_rsp_data : head_instr;
      bus.out_pc    = head_pc;
      fill_wr       = fill & ~(bypass & bus.out_ready);
   end
`else
   // Decode view: registered head entry only.
   always_comb begin
      bus.out_valid = ~bus.redirect_valid & (occ != '0) & head_dv;
      bus.out_instr = head_instr;
      bus.out_pc    = head_pc;
      fill_wr       = fill;
   end
`endif

   // Next fetch PC: redirect target (word aligned) or sequential step.
   always_comb begin
      pc_d = pc_q;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ALIGN_MASK;
      end else if (req_fire) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // Orphaned-beat count: a redirect adds every still-pending entry, less
   // the beat arriving in the redirect cycle itself, which is discarded.
   always_comb begin
      drop_sum = {1'b0, drop_q} + {1'b0, pend};
      if (bus.imem_rsp_valid && (drop_sum != '0)) begin
         drop_sum = drop_sum - (CW+1)'(1);
      end
      drop_d = drop_q;
      if (bus.redirect_valid) begin
         drop_d = (drop_sum > {1'b0, DEPTH_C}) ? DEPTH_C : drop_sum[CW-1:0];
      end else if (bus.imem_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end
   end

   // Fetch PC and drop counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   fetch_ring #(
      .XLEN  (XLEN),
      .PCLEN (PCLEN),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk          (clk),
      .rst          (reset),
      .flush_i      (bus.redirect_valid),
      .push_i       (req_fire),
      .push_pc_i    (pc_q),
      .fill_i       (fill),
      .fill_wr_i    (fill_wr),
      .fill_data_i  (bus.imem_rsp_data),
      .pop_i        (pop),
      .head_pc_o    (head_pc),
      .head_instr_o (head_instr),
      .head_dv_o    (head_dv),
      .occ_o        (occ),
      .pend_o       (pend)
   );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4, default build). A small
// in-order memory model with programmable latency answers requests;
// memory word for address A is 0xA0000000 | A.
module tb_fetch_buffer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_buffer_if #(.XLEN(32), .PCLEN(32), .DEPTH(4)) bus();

   fetch_buffer #(
      .XLEN(32), .PCLEN(32), .DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cycle   = 0;
   int lat     = 1;
   logic [31:0] q_addr  [$];
   int          q_cyc   [$];
   logic [31:0] acc_log [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 | a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic mem_clear();
      q_addr.delete();
      q_cyc.delete();
      acc_log.delete();
      bus.imem_rsp_valid = 1'b0;
   endtask

   // One clock: log an accepted request, advance, then present the next beat.
   task automatic tick();
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         q_addr.push_back(bus.imem_req_addr);
         q_cyc.push_back(cycle);
         acc_log.push_back(bus.imem_req_addr);
      end
      @(posedge clk);
      @(negedge clk);
      cycle++;
      bus.imem_rsp_valid = 1'b0;
      if (q_addr.size() != 0 && (q_cyc[0] + lat) <= cycle) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_cyc.pop_front());
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_clear();
      #1;
      reset = 1'b0;
      #1;
      cycle = 0;
   endtask

   initial begin
      reset              = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b1;
      #2;
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_pc",    bus.out_pc, 32'h0);
      chk("rst_occupancy", bus.occupancy, 0);

      // Streaming with 1-cycle memory and decode always ready.
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      cycle = 0;
      chk("t1_first_req_valid", bus.imem_req_valid, 1);
      chk("t1_first_req_addr",  bus.imem_req_addr, 32'h0);
      tick();
      chk("t1_c1_out_valid", bus.out_valid, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t1_out_valid", bus.out_valid, 1);
         chk("t1_out_pc",    bus.out_pc, 32'(4 * i));
         chk("t1_out_instr", bus.out_instr, 32'hA000_0000 | 32'(4 * i));
         if (i == 1) chk("t1_occupancy", bus.occupancy, 2);
         tick();
      end

      // Decode stalled: ring fills to DEPTH, then drains in order.
      bus.out_ready = 1'b0;
      do_reset();
      tick(); tick(); tick(); tick();
      chk("t2_full_req_valid", bus.imem_req_valid, 0);
      chk("t2_full_occupancy", bus.occupancy, 4);
      tick();
      chk("t2_head_pc", bus.out_pc, 32'h0);
      bus.out_ready = 1'b1;
      #1;
      chk("t2_no_same_cycle_reuse", bus.imem_req_valid, 0);
      chk("t2_req_count", acc_log.size(), 4);
      chk("t2_last_req",  acc_log[3], 32'hC);
      tick();
      chk("t2_refill_valid", bus.imem_req_valid, 1);
      chk("t2_refill_addr",  bus.imem_req_addr, 32'h10);
      chk("t2_occ_after_pop", bus.occupancy, 3);
      chk("t2_pop1_pc", bus.out_pc, 32'h4);
      tick();
      chk("t2_pop2_pc", bus.out_pc, 32'h8);
      tick();
      chk("t2_pop3_pc",    bus.out_pc, 32'hC);
      chk("t2_pop3_instr", bus.out_instr, 32'hA000_000C);

      // 3-cycle memory; redirect to 0x103 with 3 outstanding, beat in same cycle.
      lat = 3;
      do_reset();
      tick(); tick(); tick();
      chk("t3_beat_in_redirect_cycle", bus.imem_rsp_valid, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      #1;
      chk("t3_redir_req_valid", bus.imem_req_valid, 0);
      chk("t3_redir_out_valid", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t3_new_req_valid", bus.imem_req_valid, 1);
      chk("t3_new_req_addr",  bus.imem_req_addr, 32'h100);
      chk("t3_flushed_occ",   bus.occupancy, 0);
      tick();
      chk("t3_drop_c5", bus.out_valid, 0);
      tick();
      chk("t3_drop_c6", bus.out_valid, 0);
      tick();
      chk("t3_drop_c7", bus.out_valid, 0);
      tick();
      chk("t3_first_valid", bus.out_valid, 1);
      chk("t3_first_pc",    bus.out_pc, 32'h100);
      chk("t3_first_instr", bus.out_instr, 32'hA000_0100);

      // Memory back-pressure: request held stable, PC does not advance.
      lat = 1;
      do_reset();
      tick();
      bus.imem_req_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", bus.imem_req_valid, 1);
         chk("t4_hold_addr",  bus.imem_req_addr, 32'h4);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      #1;
      chk("t4_release_addr", bus.imem_req_addr, 32'h4);
      tick();
      chk("t4_next_addr", bus.imem_req_addr, 32'h8);
      tick();
      chk("t4_out_pc",  bus.out_pc, 32'h4);
      chk("t4_out_valid", bus.out_valid, 1);
      chk("t4_occ_before_reset", bus.occupancy, 2);

      // Async reset pulse between clock edges.
      reset = 1'b1;
      #1;
      chk("t5_async_out_valid", bus.out_valid, 0);
      chk("t5_async_occupancy", bus.occupancy, 0);
      chk("t5_async_req_valid", bus.imem_req_valid, 0);
      mem_clear();
      reset = 1'b0;
      #1;
      cycle = 0;
      chk("t5_restart_valid", bus.imem_req_valid, 1);
      chk("t5_restart_addr",  bus.imem_req_addr, 32'h0);
      tick();
      tick();
      chk("t5_restart_out_valid", bus.out_valid, 1);
      chk("t5_restart_out_pc",    bus.out_pc, 32'h0);
      chk("t5_restart_out_instr", bus.out_instr, 32'hA000_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch front end with a decoupling prefetch queue. It generates sequential PCs, issues requests to instruction memory through a valid/ready port, and accepts in-order responses that may arrive with variable latency. Fetched instructions are held in a DEPTH-entry ring and delivered to decode through a valid/ready port. A branch redirect flushes the ring and silently discards responses that are still in flight. It replaces the single-slot fetch stage between instruction memory and the decoder.

## Interface
- `XLEN`, 32: instruction width in bits.
- `PCLEN`, 32: PC width in bits.
- `DEPTH`, 4: ring entries; power of two, ≥2.
- `RESET_PC`, 0: first fetch address; low 2 bits must be 0.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req_valid`  out  1  request pending.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  PCLEN  fetch address, word aligned.
- `imem_rsp_valid`  in  1  response beat; in order, at most one per cycle, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  XLEN  instruction word.
- `redirect_valid`  in  1  branch taken, flush.
- `redirect_pc`  in  PCLEN  new fetch address; bits [1:0] ignored.
- `out_valid`  out  1  head instruction available.
- `out_ready`  in  1  decoder consumes head.
- `out_instr`  out  XLEN  head instruction.
- `out_pc`  out  PCLEN  head PC.
- `occupancy`  out  $clog2(DEPTH+1)  allocated entries.

## Operation
- Entries are allocated when a request is accepted (`imem_req_valid & imem_req_ready`). PC is written and the data-valid bit is cleared. The fetch PC then increments by 4, wrapping modulo 2^PCLEN.
- `imem_req_valid` = `occupancy < DEPTH` & ~`redirect_valid`. Slots freed by a pop are reusable only from the next cycle.
- Each accepted response fills the oldest entry without data and sets its data-valid bit. A `drop_cnt` greater than zero instead decrements `drop_cnt` and discards the beat.
- `out_valid` = head allocated & head data-valid & ~`redirect_valid`. A pop occurs on `out_valid & out_ready`.
- On a redirect cycle:
  - All entries are freed and the fetch PC is set to {`redirect_pc`[PCLEN-1:2], 2'b00}.
  - `drop_cnt` is loaded with the number of entries still awaiting data, minus 1 if `imem_rsp_valid` in the same cycle. That beat is dropped.
  - No pop and no allocation occur in that cycle.
- Push, fill and pop may occur in the same cycle, and each updates independently. `occupancy` changes by push − pop.
- The `drop_cnt` width is $clog2(DEPTH+1). It never exceeds DEPTH.
- A redirect while `drop_cnt` is nonzero adds the newly orphaned pending entries to the remaining count.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `occupancy`=0, `drop_cnt`=0, fetch PC=RESET_PC.
- First request: `imem_req_valid`=1 in the first cycle after reset deasserts.
- Request payload is stable while `imem_req_valid` is high and `imem_req_ready` is low.
- Latency from response beat to `out_valid`: 1 cycle, registered.
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and `out_ready`=1.
- Redirect: the request to the new PC is issued in the cycle after `redirect_valid`.
- Reset asserted mid-operation clears all state immediately, including `drop_cnt`. Memory must also be reset, so no orphan beats arrive afterwards.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined: when the ring has exactly one allocated entry awaiting data and a response arrives, `out_valid`, `out_instr` and `out_pc` reflect it combinationally in the same cycle. A same-cycle pop frees the entry without writing the data.
- Not defined: 1-cycle registered latency only; no combinational path from `imem_rsp_*` to `out_*`.

## Structure
- Shared package `fetch_pkg`:
  - `INSTR_BYTES`=4.
  - Entry typedef: pc, instr, data-valid.
  - `redirect_t` struct: valid, pc.
- Sub-module `fetch_ring`:
  - DEPTH-entry storage.
  - Head, fill and tail pointers of width $clog2(DEPTH), wrapping.
  - Flush input.
- Top level holds the PC register, request logic, `drop_cnt` and the bypass mux.

## Test plan
- Reset, 1-cycle memory, `out_ready`=1: `out_pc` sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, first `out_valid` 2 cycles after the first request acceptance. `out_instr` matches memory.
- `out_ready`=0, DEPTH=4: exactly 4 requests (0x0, 0x4, 0x8, 0xC), then `imem_req_valid`=0 and `occupancy`=4. Raising `out_ready` pops in order, and a request to 0x10 follows the first pop by one cycle.
- 3-cycle memory, redirect to 0x100 with 3 responses outstanding: 3 beats are discarded, the next request is 0x100 one cycle later, and the first `out_pc` is 0x100.
- `redirect_pc`=0x103 → `imem_req_addr`=0x100. A redirect in the same cycle as a response beat drops that beat.
- `imem_req_ready`=0 for 5 cycles: `imem_req_addr` held at 0x4 with `imem_req_valid` high, and the PC does not advance.
- Async reset pulsed mid-stream between clock edges: `out_valid`=0 and `occupancy`=0 immediately. After release, the first request is to RESET_PC.
